// File: rtl/pipe_mux_tree.sv
// Pipelined 2^S-to-1 selector tree, one register stage per level, valid/ready stream.
// Optional macro PIPE_MUX_RR_EN adds auto_sel and an internal round-robin index counter.
module pipe_mux_tree #(
    parameter int S = 3,
    parameter int T = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [(2**S)*T-1:0] in,
    input  logic [S-1:0]        ctrl,
`ifdef PIPE_MUX_RR_EN
    input  logic                auto_sel,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    output logic [T-1:0]        out,
    output logic [S-1:0]        out_sel,
    output logic                out_valid,
    input  logic                out_ready
);

    logic         en;
    logic         accept;
    logic [S-1:0] idx;

    // The whole pipe advances together; a stall freezes empty stages too.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign accept   = in_valid & en;

`ifdef PIPE_MUX_RR_EN
    logic [S-1:0] rr_q;
    logic [S-1:0] rr_d;

    always_comb begin
        rr_d = rr_q;
        if (accept && auto_sel) begin
            rr_d = rr_q + S'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign idx = auto_sel ? rr_q : ctrl;
`else
    assign idx = ctrl;
`endif

    genvar k, j;
    for (k = 0; k < S; k++) begin : g_stage
        localparam int N = 2**(S-1-k);
        // Only the last stage gates its load, so out holds across bubbles.
        localparam bit LOAD_ALWAYS = (k != S-1);

        logic [2*N*T-1:0] src;
        logic [S-1:0]     src_sel;
        logic             src_vld;
        logic [N*T-1:0]   data_d;
        logic [N*T-1:0]   data_q;
        logic [S-1:0]     sel_q;
        logic             vld_q;

        if (k == 0) begin : g_head
            assign src     = in;
            assign src_sel = idx;
            assign src_vld = accept;
        end else begin : g_body
            assign src     = g_stage[k-1].data_q;
            assign src_sel = g_stage[k-1].sel_q;
            assign src_vld = g_stage[k-1].vld_q;
        end

        for (j = 0; j < N; j++) begin : g_pair
            assign data_d[j*T +: T] = src_sel[k] ? src[(2*j+1)*T +: T] : src[(2*j)*T +: T];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                sel_q  <= '0;
            end else if (en) begin
                vld_q <= src_vld;
                if (LOAD_ALWAYS || src_vld) begin
                    data_q <= data_d;
                    sel_q  <= src_sel;
                end
            end
        end
    end

    assign out       = g_stage[S-1].data_q;
    assign out_sel   = g_stage[S-1].sel_q;
    assign out_valid = g_stage[S-1].vld_q;

endmodule
